// File: rtl/sar_adc_controller.sv
// Successive-approximation conversion controller: binary-searches the DAC code
// MSB first, taking one comparator decision per bit after a settling delay.
module sar_adc_controller #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 3
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             abort,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             cmp_err
);

  localparam int IW = $clog2(WIDTH);
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [0:0] {IDLE, TRIAL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dac_code_q, dac_code_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cmp_err_q, cmp_err_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] decided;
  logic [WIDTH-1:0] next_trial;
  logic [IW-1:0]    idx_m1;

  // Current bit resolved from the comparator, and the code for the next trial.
  always_comb begin
    idx_m1     = bit_idx_q - IW'(1);
    decided    = dac_code_q;
    if (down) decided[bit_idx_q] = 1'b0;
    next_trial = decided;
    next_trial[idx_m1] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    dac_code_d = dac_code_q;
    result_d   = result_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cmp_err_d  = cmp_err_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = TRIAL;
          bit_idx_d  = IW'(WIDTH - 1);
          dac_code_d = {1'b1, {(WIDTH-1){1'b0}}};
          cnt_d      = CW'(SETTLE);
          busy_d     = 1'b1;
          cmp_err_d  = 1'b0;
        end
      end
      TRIAL: begin
        if (abort) begin
          state_d    = IDLE;
          dac_code_d = '0;
          busy_d     = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Sample edge: a contradictory comparator reading still clears the bit.
          if (up && down) cmp_err_d = 1'b1;
          if (bit_idx_q != '0) begin
            dac_code_d = next_trial;
            bit_idx_d  = idx_m1;
            cnt_d      = CW'(SETTLE);
          end else begin
            dac_code_d = decided;
            result_d   = decided;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      dac_code_q <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmp_err_q  <= 1'b0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      dac_code_q <= dac_code_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmp_err_q  <= cmp_err_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dac_code = dac_code_q;
  assign result   = result_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cmp_err  = cmp_err_q;

endmodule

// File: tb/tb_sar_adc_controller.sv
// Self-checking bench for sar_adc_controller: table vectors, corner sequences
// and random analog inputs against an arithmetic binary-search model.
module tb_sar_adc_controller;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 3;
  localparam int LAT    = WIDTH * (SETTLE + 1);

  logic             clock = 1'b0;
  logic             clear = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             up, down;
  logic [WIDTH-1:0] dac_code, result;
  logic             busy, done, cmp_err;
  logic             force_both = 1'b0;

  logic             start0 = 1'b0;
  logic             abort0 = 1'b0;
  logic             up0, down0;
  logic [WIDTH-1:0] dac0, result0;
  logic             busy0, done0, err0;

  real vin = 0.0;
  int  checks = 0;
  int  errors = 0;

  always #5 clock = ~clock;

  // Analog comparator: +/-0.01 dead band around code/10.
  assign up    = force_both || (vin > real'(dac_code) / 10.0 + 0.01);
  assign down  = force_both || (vin < real'(dac_code) / 10.0 - 0.01);
  assign up0   = (vin > real'(dac0) / 10.0 + 0.01);
  assign down0 = (vin < real'(dac0) / 10.0 - 0.01);

  sar_adc_controller #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clock(clock), .clear(clear), .start(start), .abort(abort),
    .up(up), .down(down), .dac_code(dac_code), .result(result),
    .busy(busy), .done(done), .cmp_err(cmp_err)
  );

  sar_adc_controller #(.WIDTH(WIDTH), .SETTLE(0)) dut0 (
    .clock(clock), .clear(clear), .start(start0), .abort(abort0),
    .up(up0), .down(down0), .dac_code(dac0), .result(result0),
    .busy(busy0), .done(done0), .cmp_err(err0)
  );

  typedef struct {
    real        vin;
    logic [7:0] exp_result;
    bit         chk_trials;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] exp_trials [8];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Binary search in plain arithmetic; force_bit marks a bit decided as "below".
  function automatic logic [7:0] ref_convert(input real v, input int force_bit);
    int code = 0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      code += (1 << k);
      if (k == force_bit || v < real'(code) / 10.0 - 0.01) code -= (1 << k);
    end
    return 8'(code);
  endfunction

  task automatic apply_stimulus(input real v, input logic [7:0] exp_res, input int abort_at,
                                input int start_at, input int force_bit, input bit chk_trials);
    logic [7:0] prev_dac, res_before;
    logic [7:0] trials [$];
    int done_at, done_cnt, bad_busy, bad_dac;
    bit exp_err;
    exp_err = (force_bit >= 0);
    res_before = result;
    done_at = -1; done_cnt = 0; bad_busy = 0; bad_dac = 0;
    vin = v;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    check_output("start_busy", busy, 1);
    check_output("start_dac", dac_code, 128);
    check_output("start_err_clr", cmp_err, 0);
    prev_dac = dac_code;
    trials.push_back(dac_code);
    for (int n = 1; n <= LAT + 1; n++) begin
      abort = (n == abort_at);
      start = (n == start_at);
      force_both = (force_bit >= 0) && (n == (WIDTH - force_bit) * (SETTLE + 1));
      @(posedge clock); #1;
      abort = 1'b0; start = 1'b0; force_both = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (n == abort_at) begin
        check_output("abort_busy", busy, 0);
        check_output("abort_dac", dac_code, 0);
        check_output("abort_result", result, res_before);
        check_output("abort_busy_before", bad_busy, 0);
        repeat (LAT) begin
          @(posedge clock); #1;
          if (done) done_cnt++;
        end
        check_output("abort_no_done", done_cnt, 0);
        return;
      end
      if (n < LAT) begin
        if (!busy) bad_busy++;
        if (n % (SETTLE + 1) == 0) trials.push_back(dac_code);
        else if (dac_code !== prev_dac) bad_dac++;
      end else if (busy) begin
        bad_busy++;
      end
      prev_dac = dac_code;
    end
    check_output("busy_window", bad_busy, 0);
    check_output("dac_stable", bad_dac, 0);
    check_output("done_time", done_at, LAT);
    check_output("done_width", done_cnt, 1);
    check_output("result", result, exp_res);
    check_output("final_dac", dac_code, exp_res);
    check_output("cmp_err", cmp_err, exp_err);
    if (chk_trials) begin
      check_output("trial_count", trials.size(), 8);
      for (int i = 0; i < 8 && i < trials.size(); i++)
        check_output($sformatf("trial%0d", i), trials[i], exp_trials[i]);
    end
  endtask

  initial begin
    int n;
    real v;
    vecs[0] = '{0.0,  8'd0,   1'b0};
    vecs[1] = '{25.5, 8'd255, 1'b0};
    vecs[2] = '{10.0, 8'd100, 1'b0};
    vecs[3] = '{0.55, 8'd5,   1'b0};
    vecs[4] = '{1.8,  8'd18,  1'b1};
    exp_trials = '{8'd128, 8'd64, 8'd32, 8'd16, 8'd24, 8'd20, 8'd18, 8'd19};

    #1 clear = 1'b0;
    #2;
    check_output("rst_dac", dac_code, 0);
    check_output("rst_result", result, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", cmp_err, 0);
    @(negedge clock); clear = 1'b1;

    for (int i = 0; i < 5; i++)
      apply_stimulus(vecs[i].vin, vecs[i].exp_result, -1, -1, -1, vecs[i].chk_trials);

    // Abort mid-conversion keeps the previous result (18).
    apply_stimulus(5.0, 8'd18, 10, -1, -1, 1'b0);
    // A start while busy is ignored.
    apply_stimulus(1.8, 8'd18, -1, 5, -1, 1'b1);
    // Contradictory comparator at the bit-5 sample.
    apply_stimulus(25.5, ref_convert(25.5, 5), -1, -1, 5, 1'b0);

    for (int i = 0; i < 6; i++) begin
      v = real'($urandom_range(0, 2700)) / 100.0;
      apply_stimulus(v, ref_convert(v, -1), -1, -1, -1, 1'b0);
    end

    // Asynchronous clear part-way through a conversion.
    vin = 1.8;
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (17) @(posedge clock);
    #3 clear = 1'b0;
    #1;
    check_output("clr_dac", dac_code, 0);
    check_output("clr_result", result, 0);
    check_output("clr_busy", busy, 0);
    check_output("clr_done", done, 0);
    @(negedge clock); clear = 1'b1;
    apply_stimulus(1.8, 8'd18, -1, -1, -1, 1'b1);

    // SETTLE=0 build, back-to-back with start held high.
    vin = 0.55;
    @(negedge clock); start0 = 1'b1;
    @(posedge clock); #1;
    check_output("s0_busy", busy0, 1);
    n = 0;
    while (!done0 && n < 20) begin @(posedge clock); #1; n++; end
    check_output("s0_latency", n, 8);
    check_output("s0_result", result0, 5);
    check_output("s0_done_busy", busy0, 0);
    @(posedge clock); #1;
    check_output("s0_b2b_busy", busy0, 1);
    check_output("s0_b2b_dac", dac0, 128);
    start0 = 1'b0;
    n = 0;
    while (!done0 && n < 20) begin @(posedge clock); #1; n++; end
    check_output("s0_latency2", n, 8);
    check_output("s0_result2", result0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_adc_controller.md
# sar_adc_controller

Successive-approximation controller for the analog-to-digital converter datapath. On a start request it drives trial codes into the DAC, waits a programmable settling interval, samples the analog comparator's `up`/`down` decision, and resolves one result bit per step, MSB first. It replaces the free-running up/down tracking counter when a bounded-latency, one-shot conversion is required, and presents a start/busy/done handshake to the digital side.

## Interface

- `WIDTH`, 8: result and DAC code width in bits (≥2).
- `SETTLE`, 3: wait cycles after each DAC code change before the comparator is sampled. Covers DAC plus comparator delay. 0 is legal.

- `clock`  in  1  Rising-edge clock.
- `clear`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Conversion request. Sampled only in IDLE.
- `abort`  in  1  Synchronous cancel. Honoured only while busy.
- `up`  in  1  Comparator: analog input above DAC output.
- `down`  in  1  Comparator: analog input below DAC output.
- `dac_code`  out  WIDTH  Code driven to the DAC.
- `result`  out  WIDTH  Last completed conversion. Held until the next completion.
- `busy`  out  1  High while converting.
- `done`  out  1  One-cycle pulse when `result` updates.
- `cmp_err`  out  1  Sticky flag: `up` and `down` were both high at a sample point.

## Operation

- One clock, `clock`. Reset is asynchronous and active-low, on `clear`.
- Reset values: state IDLE; `dac_code`=0, `result`=0, `busy`=0, `done`=0, `cmp_err`=0; bit index and settle counter 0.
- States:
  - IDLE
  - TRIAL
  - DONE, a single-cycle state that is folded into the return to IDLE.
- IDLE, on `start`=1 at an edge:
  - Go to TRIAL.
  - Bit index i = WIDTH-1.
  - `dac_code` = 1<<(WIDTH-1), with all other bits 0.
  - Settle counter = SETTLE.
  - `busy`=1, `cmp_err`=0.
- TRIAL, counter > 0: decrement the counter. Nothing else changes.
- TRIAL, counter = 0 (the sample edge):
  - If `down`=1, clear bit i of `dac_code`. This includes `up`=`down`=1, which also sets `cmp_err`.
  - Otherwise keep bit i. "Close" (both low) counts as keep.
  - If i > 0: set bit i-1, decrement i, reload the counter with SETTLE.
  - If i = 0: `result` takes the decided code, `done`=1 for this cycle only, `busy`=0, return to IDLE.
- `dac_code` holds the final code after completion. DAC feedback then equals `result`.
- Decisions use only the comparator value present at the sample edge. Comparator values between sample edges are ignored.
- `abort`=1 while busy:
  - Next edge returns to IDLE with `dac_code`=0, `busy`=0.
  - No `done`. `result` and `cmp_err` are unchanged.
  - `abort` takes priority over a simultaneous sample-edge decision.
- `abort` in IDLE is ignored. `start` while busy is ignored; requests are not queued.
- `abort` and `start` both high in IDLE: the conversion starts.
- `clear` asserted mid-conversion: immediate return to reset values. Partial code discarded.

## Timing

- Edge E0 accepts `start`. `busy` and the first trial `dac_code` are visible after E0.
- Each bit takes SETTLE+1 edges. The sample edge for bit k (k=WIDTH-1…0) is E0+(WIDTH-k)(SETTLE+1).
- Completion is at E0+WIDTH·(SETTLE+1): `done` is high for the following cycle, `busy` is low, `result` is valid. Default latency is 32 cycles.
- `start` held high across the completion edge has no effect at that edge. It is accepted at the next edge, E0'=completion+1, so there is 1 idle cycle between conversions minimum.
- `dac_code` changes only at E0, at sample edges, and at abort/reset. It is never glitched mid-settle.
- All outputs are registered. There is no combinational path from `up`/`down` to any output.

## Test plan

Bench comparator model:
- `up` = vin > code/10+0.01
- `down` = vin < code/10−0.01

Scenarios:
- vin=1.8, pulse `start` → trial sequence 128,64,32,16,24,20,18,19 → `result`=18 (0x12), `done` pulse exactly 32 cycles after E0, `busy` high for cycles 1–32.
- vin=25.5 → every bit kept, `result`=255. vin=0.0 → every bit cleared, `result`=0, final `dac_code`=0.
- vin=0.55, SETTLE=0 build → `result`=5, latency 8 cycles. Back-to-back with `start` held high: second E0 is 1 cycle after the first `done`.
- Force `up`=`down`=1 at the bit-5 sample → bit 5 cleared, `cmp_err`=1 and held through `done`. Next accepted `start` clears it.
- Assert `abort` at cycle 10 of a conversion → `busy`=0 and `dac_code`=0 one edge later, no `done`, `result` keeps its prior value (18). `start` during busy at cycle 5 → ignored, completion timing unchanged.
- Drop `clear` asynchronously at cycle 17 → all outputs 0 immediately. Release, then `start` → full 32-cycle conversion with correct result.
